// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the MDU issue controller: MDUOP encodings, ReadHILO
// encodings, default latencies, the IDLE/BUSY state type and op-class helpers.
// -----------------------------------------------------------------------------
package mdu_pkg;

    // MDUOP / E-stage op class encodings
    localparam logic [3:0] MDU_NONE  = 4'b0000;
    localparam logic [3:0] MDU_MULT  = 4'b0001;
    localparam logic [3:0] MDU_MULTU = 4'b0010;
    localparam logic [3:0] MDU_DIV   = 4'b0011;
    localparam logic [3:0] MDU_DIVU  = 4'b0100;
    localparam logic [3:0] MDU_MTHI  = 4'b0101;
    localparam logic [3:0] MDU_MTLO  = 4'b0110;
    localparam logic [3:0] MDU_MFHI  = 4'b0111;
    localparam logic [3:0] MDU_MFLO  = 4'b1000;

    // ReadHILO encodings
    localparam logic [1:0] READ_NONE = 2'b00;
    localparam logic [1:0] READ_LO   = 2'b01;
    localparam logic [1:0] READ_HI   = 2'b10;

    // Default latencies loaded into Time
    localparam int DEF_MUL_CYCLES = 5;
    localparam int DEF_DIV_CYCLES = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Multiply/divide ops: the ones that start a timed MDU operation
    function automatic logic is_md_op(input logic [3:0] op);
        return (op >= MDU_MULT) && (op <= MDU_DIVU);
    endfunction

    // Any op that touches the MDU (start, HI/LO write or HI/LO read)
    function automatic logic is_mdu_op(input logic [3:0] op);
        return (op >= MDU_MULT) && (op <= MDU_MFLO);
    endfunction

endpackage : mdu_pkg

// File: rtl/mdu_lat_counter.sv
// -----------------------------------------------------------------------------
// mdu_lat_counter
// Latency counter tracking the in-flight MDU operation. Loaded with the
// operation's Time on start, then counts down to zero.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   load            load load_val this edge (Start pulse)
//   load_val[3:0]   latency to load
//   cnt[3:0]        current count
//   busy            registered state: 1 while cnt != 0
// -----------------------------------------------------------------------------
module mdu_lat_counter
    import mdu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] cnt,
    output logic       busy
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    mdu_state_e state_q;
    mdu_state_e state_d;

    // Next-count: load on start, otherwise count down and hold at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
        // State is kept registered alongside cnt so busy comes straight from a flop
        state_d = (cnt_d != 4'd0) ? ST_BUSY : ST_IDLE;
    end

    // Counter and IDLE/BUSY state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 4'd0;
            state_q <= ST_IDLE;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign cnt  = cnt_q;
    assign busy = (state_q == ST_BUSY);

endmodule : mdu_lat_counter

// File: rtl/mdu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_issue_ctrl
// E-stage controller in front of the multiply/divide unit. Decodes the MDU op
// class in E, drives Start/MDUOP/Time/ReadHILO and stalls MDU-class ops that
// meet an in-flight operation. Stall and Start come from an internal latency
// counter rather than the MDU's Busy, because Busy already contains Start.
//
// Build option: define MDU_BUSY_CHECK_EN to compare the internal busy view
// against mdu_busy every cycle and raise the sticky busy_mismatch flag.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   e_valid, e_flush  E-stage live / kill
//   e_mdu_op[3:0]     op class of the instruction in E
//   mdu_busy          MDU Busy (only observed by the optional check)
//   start             one-cycle Start pulse
//   mduop[3:0]        MDUOP
//   time_cfg[3:0]     Time (latency) valid with start
//   read_hilo[1:0]    01 = LO, 10 = HI, 00 = none
//   stall             freeze F/D/E, bubble into M
//   busy_mismatch     sticky Busy protocol-error flag
// -----------------------------------------------------------------------------
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e_valid,
    input  logic       e_flush,
    input  logic [3:0] e_mdu_op,
    input  logic       mdu_busy,
    output logic       start,
    output logic [3:0] mduop,
    output logic [3:0] time_cfg,
    output logic [1:0] read_hilo,
    output logic       stall,
    output logic       busy_mismatch
);

    localparam logic [3:0] MUL_T = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_T = 4'(DIV_CYCLES);

    logic       live_s;
    logic       busy_s;
    logic [3:0] cnt_s;

    mdu_lat_counter u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (start),
        .load_val (time_cfg),
        .cnt      (cnt_s),
        .busy     (busy_s)
    );

    // Issue decode; reset is folded into live so every output is 0 during reset
    always_comb begin
        live_s    = e_valid && !e_flush && !reset;
        stall     = live_s && is_mdu_op(e_mdu_op) && busy_s;
        start     = live_s && is_md_op(e_mdu_op) && !busy_s;
        time_cfg  = 4'd0;
        mduop     = MDU_NONE;
        read_hilo = READ_NONE;

        if (start) begin
            case (e_mdu_op)
                MDU_MULT, MDU_MULTU: time_cfg = MUL_T;
                MDU_DIV,  MDU_DIVU:  time_cfg = DIV_T;
                default:             time_cfg = 4'd0;
            endcase
        end else begin
            time_cfg = 4'd0;
        end

        // mthi/mtlo/mfhi/mflo only reach the MDU once it is idle
        if (live_s && !stall) begin
            mduop = e_mdu_op;
            case (e_mdu_op)
                MDU_MFHI: read_hilo = READ_HI;
                MDU_MFLO: read_hilo = READ_LO;
                default:  read_hilo = READ_NONE;
            endcase
        end else begin
            mduop     = MDU_NONE;
            read_hilo = READ_NONE;
        end
    end

`ifdef MDU_BUSY_CHECK_EN
    logic busy_mismatch_q;
    logic busy_mismatch_d;

    // Sticky flag: the MDU's Busy must equal (counter running || start)
    always_comb begin
        if ((busy_s || start) != mdu_busy) begin
            busy_mismatch_d = 1'b1;
        end else begin
            busy_mismatch_d = busy_mismatch_q;
        end
    end

    // Protocol-error flag register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_mismatch_q <= 1'b0;
        end else begin
            busy_mismatch_q <= busy_mismatch_d;
        end
    end

    assign busy_mismatch = busy_mismatch_q;
`else
    logic unused_mdu_busy_s;
    assign unused_mdu_busy_s = mdu_busy;
    assign busy_mismatch     = 1'b0;
`endif

    // cnt is only needed for its busy view here
    logic unused_cnt_s;
    assign unused_cnt_s = ^cnt_s;

endmodule : mdu_issue_ctrl

// File: tb/tb_mdu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_issue_ctrl
// Table-driven directed bench for mdu_issue_ctrl (MUL_CYCLES=5, DIV_CYCLES=10).
// Inputs change 1 ns after posedge, outputs are sampled 4 ns after posedge.
// -----------------------------------------------------------------------------
module tb_mdu_issue_ctrl;

    logic       clk;
    logic       reset;
    logic       e_valid;
    logic       e_flush;
    logic [3:0] e_mdu_op;
    logic       mdu_busy;
    logic       start;
    logic [3:0] mduop;
    logic [3:0] time_cfg;
    logic [1:0] read_hilo;
    logic       stall;
    logic       busy_mismatch;

    int n_vec;
    int n_fail;

    mdu_issue_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .e_valid       (e_valid),
        .e_flush       (e_flush),
        .e_mdu_op      (e_mdu_op),
        .mdu_busy      (mdu_busy),
        .start         (start),
        .mduop         (mduop),
        .time_cfg      (time_cfg),
        .read_hilo     (read_hilo),
        .stall         (stall),
        .busy_mismatch (busy_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       f;
        logic [3:0] op;
        logic       mb;
        logic       st;
        logic [3:0] mo;
        logic [3:0] tc;
        logic [1:0] rh;
        logic       sl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic f, input logic [3:0] op,
                                input logic mb, input logic st, input logic [3:0] mo,
                                input logic [3:0] tc, input logic [1:0] rh, input logic sl);
        vec_t r;
        r.v = v; r.f = f; r.op = op; r.mb = mb;
        r.st = st; r.mo = mo; r.tc = tc; r.rh = rh; r.sl = sl;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input int idx, input logic st, input logic [3:0] mo,
                              input logic [3:0] tc, input logic [1:0] rh, input logic sl);
        check("start",     idx, {7'd0, start},     {7'd0, st});
        check("mduop",     idx, {4'd0, mduop},     {4'd0, mo});
        check("time_cfg",  idx, {4'd0, time_cfg},  {4'd0, tc});
        check("read_hilo", idx, {6'd0, read_hilo}, {6'd0, rh});
        check("stall",     idx, {7'd0, stall},     {7'd0, sl});
    endtask

    task automatic drive(input logic v, input logic f, input logic [3:0] op, input logic mb);
        e_valid = v; e_flush = f; e_mdu_op = op; mdu_busy = mb;
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 1'b0);

        // mult + mflo: issue, 5 stall cycles, then read LO
        tbl.push_back(mk(1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 4'd1, 4'd5, 2'b00, 1'b0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 4'd8, 4'd0, 2'b01, 1'b0));
        // divu then back-to-back multu: 10 stall cycles, then issue
        tbl.push_back(mk(1'b1, 1'b0, 4'd4, 1'b1, 1'b1, 4'd4, 4'd10, 2'b00, 1'b0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 4'd2, 4'd5, 2'b00, 1'b0));
        // non-MDU while busy never stalls (cnt 5,4,3)
        tbl.push_back(mk(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0));
        // mthi at cnt 2: held 2 cycles, then passes with no start
        tbl.push_back(mk(1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 1'b1));
        tbl.push_back(mk(1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 4'd5, 4'd0, 2'b00, 1'b0));
        // flushed div: no start, counter stays 0 so following ops issue at once
        tbl.push_back(mk(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 4'd8, 4'd0, 2'b01, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 4'd7, 1'b0, 1'b0, 4'd7, 4'd0, 2'b10, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 4'd6, 1'b0, 1'b0, 4'd6, 4'd0, 2'b00, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0));
        // mult, then flushed mflo while busy (no stall), then live mflo stalls
        tbl.push_back(mk(1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 4'd1, 4'd5, 2'b00, 1'b0));
        tbl.push_back(mk(1'b1, 1'b1, 4'd8, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 4'd0, 4'd0, 2'b00, 1'b1));

        // Reset state: all outputs 0 while reset is high, even with a mult in E
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 4'd1, 1'b0);
        #3;
        check_outs(-1, 1'b0, 4'd0, 4'd0, 2'b00, 1'b0);
        check("busy_mismatch", -1, {7'd0, busy_mismatch}, 8'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 4'd0, 1'b0);

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            drive(tbl[i].v, tbl[i].f, tbl[i].op, tbl[i].mb);
            #3;
            check_outs(i, tbl[i].st, tbl[i].mo, tbl[i].tc, tbl[i].rh, tbl[i].sl);
            check("busy_mismatch", i, {7'd0, busy_mismatch}, 8'd0);
        end

        // Mid-BUSY reset (cnt = 3): stall drops at once, no start, counter cleared
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 4'd8, 1'b1);
        #3;
        check("pre_reset_stall", 100, {7'd0, stall}, 8'd1);
        #1;
        reset = 1'b1;
        #1;
        check("reset_stall", 101, {7'd0, stall}, 8'd0);
        drive(1'b1, 1'b0, 4'd3, 1'b0);
        #1;
        check("reset_start", 102, {7'd0, start}, 8'd0);
        check("reset_mduop", 102, {4'd0, mduop}, 8'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        // Counter restarted from 0: a div issues immediately with Time = 10
        drive(1'b1, 1'b0, 4'd3, 1'b1);
        #3;
        check_outs(103, 1'b1, 4'd3, 4'd10, 2'b00, 1'b0);

        // Busy check: claim MDU idle during a BUSY cycle
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'd0, 1'b0);
        #3;
        check("mismatch_before_edge", 104, {7'd0, busy_mismatch}, 8'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'd0, 1'b1);
`ifdef MDU_BUSY_CHECK_EN
        check("mismatch_set", 105, {7'd0, busy_mismatch}, 8'd1);
        @(posedge clk); #1;
        check("mismatch_sticky", 106, {7'd0, busy_mismatch}, 8'd1);
`else
        check("mismatch_tied", 105, {7'd0, busy_mismatch}, 8'd0);
        @(posedge clk); #1;
        check("mismatch_tied2", 106, {7'd0, busy_mismatch}, 8'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_mdu_issue_ctrl
